// File: rtl/mem_port_arbiter.sv
// N-channel request latch, arbiter and byte-serial RAM port sequencer.
// Reads are drained through a latency pipe; flush aborts reads only.
module mem_port_arbiter #(
    parameter  int NCH       = 3,
    parameter  int ADR_W     = 17,
    parameter  int DAT_W     = 32,
    parameter  int RD_LAT    = 1,
    parameter  int PRIO_MODE = 0,
    localparam int NB        = DAT_W / 8,
    localparam int LEN_W     = $clog2(NB) + 1,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req_i,
    input  logic [NCH-1:0]         rw_i,
    input  logic [NCH*LEN_W-1:0]   len_i,
    input  logic [NCH*ADR_W-1:0]   adr_i,
    input  logic [NCH*DAT_W-1:0]   wdat_i,
    input  logic                   flush_i,
    output logic [NCH-1:0]         done_o,
    output logic [NCH*DAT_W-1:0]   rdat_o,
    output logic                   busy_o,
    output logic [ADR_W-1:0]       ram_adr_o,
    output logic [7:0]             ram_dat_o,
    output logic                   ram_rwen_o,
    input  logic [7:0]             ram_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NCH-1:0]       r_pend;
    logic [NCH-1:0]       r_rw;
    logic [NCH-1:0]       r_done;
    logic [LEN_W-1:0]     r_len  [NCH];
    logic [ADR_W-1:0]     r_adr  [NCH];
    logic [DAT_W-1:0]     r_wdat [NCH];
    logic [NCH*DAT_W-1:0] r_rdat;
    logic [CH_W-1:0]      r_cur;
    logic [CH_W-1:0]      r_last;
    logic [LEN_W-1:0]     r_k;
    logic [LEN_W-1:0]     r_cap;
    logic [DAT_W-1:0]     r_buf;
    logic [RD_LAT-1:0]    r_vpipe;

    logic [NCH-1:0]       w_pend_eff;
    logic [NCH-1:0]       w_active;
    logic [LEN_W-1:0]     w_len_in [NCH];
    logic                 w_grant_any;
    logic [CH_W-1:0]      w_grant_ch;
    logic                 w_cur_rw;
    logic [LEN_W-1:0]     w_cur_len;
    logic [ADR_W-1:0]     w_cur_adr;
    logic [DAT_W-1:0]     w_cur_wdat;
    logic                 w_busy;
    logic                 w_last_beat;
    logic                 w_abort;
    logic                 w_issue;
    logic                 w_cap;
    logic                 w_cap_last;
    logic [DAT_W-1:0]     w_buf_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [LEN_W-1:0] w_raw;
        assign w_raw = len_i[g*LEN_W +: LEN_W];
        assign w_len_in[g] = (w_raw == '0 || w_raw > LEN_W'(NB))
                           ? LEN_W'(NB) : w_raw;
        assign w_active[g] = w_busy && (r_cur == CH_W'(g));
    end

    assign w_busy      = (r_state != S_IDLE);
    assign w_cur_rw    = r_rw[r_cur];
    assign w_cur_len   = r_len[r_cur];
    assign w_cur_adr   = r_adr[r_cur];
    assign w_cur_wdat  = r_wdat[r_cur];
    assign w_pend_eff  = flush_i ? (r_pend & r_rw) : r_pend;
    assign w_last_beat = (r_k == w_cur_len - 1'b1);
    assign w_abort     = flush_i && w_busy && !w_cur_rw;
    assign w_issue     = (r_state == S_XFER) && !w_cur_rw && !w_abort;
    assign w_cap       = r_vpipe[RD_LAT-1];
    assign w_cap_last  = w_cap && (r_cap == w_cur_len - 1'b1);
    assign w_buf_nxt   = r_buf | (DAT_W'(ram_dat_i) << {r_cap, 3'b000});

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_ch  = '0;
        if (PRIO_MODE != 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (w_pend_eff[i]) begin
                    w_grant_any = 1'b1;
                    w_grant_ch  = CH_W'(i);
                end
            end
        end else begin
            // Walk backwards so the nearest channel after r_last wins.
            for (int i = NCH; i >= 1; i--) begin
                if (w_pend_eff[(int'(r_last) + i) % NCH]) begin
                    w_grant_any = 1'b1;
                    w_grant_ch  = CH_W'((int'(r_last) + i) % NCH);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_abort)
                    w_state_nxt = S_IDLE;
                else if (w_last_beat)
                    w_state_nxt = w_cur_rw ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_abort || w_cap_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_rw    <= '0;
            r_done  <= '0;
            r_rdat  <= '0;
            r_cur   <= '0;
            r_last  <= CH_W'(NCH - 1);
            r_k     <= '0;
            r_cap   <= '0;
            r_buf   <= '0;
            r_vpipe <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_len[c]  <= '0;
                r_adr[c]  <= '0;
                r_wdat[c] <= '0;
            end
        end else begin
            r_done <= '0;
            for (int c = 0; c < NCH; c++) begin
                if (req_i[c] && !r_pend[c] && !w_active[c] &&
                    !(flush_i && !rw_i[c])) begin
                    r_pend[c] <= 1'b1;
                    r_rw[c]   <= rw_i[c];
                    r_len[c]  <= w_len_in[c];
                    r_adr[c]  <= adr_i[c*ADR_W +: ADR_W];
                    r_wdat[c] <= wdat_i[c*DAT_W +: DAT_W];
                end else if ((flush_i && !r_rw[c]) ||
                             (r_state == S_IDLE && w_grant_any &&
                              w_grant_ch == CH_W'(c))) begin
                    r_pend[c] <= 1'b0;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_cur   <= w_grant_ch;
                        r_last  <= w_grant_ch;
                        r_k     <= '0;
                        r_cap   <= '0;
                        r_buf   <= '0;
                        r_vpipe <= '0;
                    end
                end
                default: begin
                    if (r_state == S_XFER) r_k <= r_k + 1'b1;
                    // Each issued read beat surfaces RD_LAT cycles later.
                    if (w_abort) r_vpipe <= '0;
                    else r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_issue);
                    if (w_cap) begin
                        r_buf <= w_buf_nxt;
                        r_cap <= r_cap + 1'b1;
                    end
                    if (r_state == S_XFER && w_cur_rw && w_last_beat)
                        r_done[r_cur] <= 1'b1;
                    if (r_state == S_DRAIN && w_cap_last && !w_abort) begin
                        r_done[r_cur] <= 1'b1;
                        r_rdat[int'(r_cur)*DAT_W +: DAT_W] <= w_buf_nxt;
                    end
                end
            endcase
        end
    end

    assign done_o     = r_done;
    assign rdat_o     = r_rdat;
    assign busy_o     = w_busy;
    assign ram_rwen_o = (r_state == S_XFER) && w_cur_rw;
    assign ram_adr_o  = (r_state == S_XFER) ? w_cur_adr + ADR_W'(r_k) : '0;
    assign ram_dat_o  = ram_rwen_o ? w_cur_wdat[{r_k, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: round-robin and fixed-priority
// instances, a latency-1 RAM model, and queued done/write expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_rr, req_fp, rw_v;
    logic [8:0]  len_v;
    logic [50:0] adr_v;
    logic [95:0] wdat_v;
    logic        flush;
    logic [7:0]  zero_b;

    logic [2:0]  done_rr, done_fp;
    logic [95:0] rdat_rr, rdat_fp;
    logic        busy_rr, busy_fp;
    logic [16:0] radr_rr, radr_fp;
    logic [7:0]  rdo_rr, rdo_fp;
    logic        rwen_rr, rwen_fp;
    logic [7:0]  rdi_rr;

    mem_port_arbiter #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .req_i(req_rr), .rw_i(rw_v),
        .len_i(len_v), .adr_i(adr_v), .wdat_i(wdat_v),
        .flush_i(flush), .done_o(done_rr), .rdat_o(rdat_rr),
        .busy_o(busy_rr), .ram_adr_o(radr_rr), .ram_dat_o(rdo_rr),
        .ram_rwen_o(rwen_rr), .ram_dat_i(rdi_rr)
    );

    mem_port_arbiter #(.PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .req_i(req_fp), .rw_i(rw_v),
        .len_i(len_v), .adr_i(adr_v), .wdat_i(wdat_v),
        .flush_i(flush), .done_o(done_fp), .rdat_o(rdat_fp),
        .busy_o(busy_fp), .ram_adr_o(radr_fp), .ram_dat_o(rdo_fp),
        .ram_rwen_o(rwen_fp), .ram_dat_i(zero_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mem [0:131071];
    logic [16:0] adr_d = '0;
    always @(posedge clk) adr_d <= radr_rr;
    assign rdi_rr = mem[adr_d];

    typedef struct {
        int          ch;
        int          cyc;
        logic [31:0] rdat;
        bit          rd;
    } done_t;

    typedef struct {
        logic [16:0] adr;
        logic [7:0]  dat;
    } wr_t;

    done_t exp_q[$];
    done_t fp_q[$];
    wr_t   wq[$];
    done_t de, fe;
    wr_t   we;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_rr != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("rr_unexpected_done", 64'(done_rr), 64'd0);
            end else begin
                de = exp_q.pop_front();
                check("rr_done_ch", 64'(done_rr), 64'(3'b001 << de.ch));
                check("rr_done_cyc", 64'(cyc), 64'(de.cyc));
                if (de.rd)
                    check("rr_rdat", 64'(rdat_rr[de.ch*32 +: 32]),
                          64'(de.rdat));
            end
        end
        if (done_fp != 3'b000) begin
            if (fp_q.size() == 0) begin
                check("fp_unexpected_done", 64'(done_fp), 64'd0);
            end else begin
                fe = fp_q.pop_front();
                check("fp_done_ch", 64'(done_fp), 64'(3'b001 << fe.ch));
                check("fp_done_cyc", 64'(cyc), 64'(fe.cyc));
            end
        end
        if (rwen_rr) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 64'(radr_rr), 64'h1ffff_ffff);
            end else begin
                we = wq.pop_front();
                check("wr_adr", 64'(radr_rr), 64'(we.adr));
                check("wr_dat", 64'(rdo_rr), 64'(we.dat));
            end
        end
    end

    task automatic set_ch(input int c, input logic rw, input int len,
                          input logic [16:0] a, input logic [31:0] d);
        rw_v[c]            = rw;
        len_v[c*3 +: 3]    = 3'(len);
        adr_v[c*17 +: 17]  = a;
        wdat_v[c*32 +: 32] = d;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() + fp_q.size() + wq.size() != 0 ||
                busy_rr || busy_fp) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(exp_q.size() + fp_q.size() + wq.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_done"}, 64'(done_rr), 64'd0);
        for (int c = 0; c < 3; c++)
            check({tag, "_rdat"}, 64'(rdat_rr[c*32 +: 32]), 64'd0);
        check({tag, "_busy"}, 64'(busy_rr), 64'd0);
        check({tag, "_ram_adr"}, 64'(radr_rr), 64'd0);
        check({tag, "_ram_dat"}, 64'(rdo_rr), 64'd0);
        check({tag, "_ram_rwen"}, 64'(rwen_rr), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, nrr, nfp;
        int rr_ord [6];
        int fp_ord [6];
        rr_ord = '{0, 1, 2, 0, 1, 2};
        fp_ord = '{0, 1, 0, 1, 0, 2};
        req_rr = '0; req_fp = '0; rw_v = '0; len_v = '0;
        adr_v = '0; wdat_v = '0; flush = 1'b0; zero_b = 8'h00;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h10] = 8'h11; mem[17'h11] = 8'h22;
        mem[17'h12] = 8'h33; mem[17'h13] = 8'h44;
        mem[17'h20] = 8'h99; mem[17'h21] = 8'h88;
        mem[17'h22] = 8'h77; mem[17'h23] = 8'h66;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three-way contention, re-request on the first three dones.
        for (int c = 0; c < 3; c++)
            set_ch(c, 1'b1, 1, 17'(32'h100 + c), 32'h0000_00A0 + c);
        n = cyc;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{rr_ord[i], n + 3 + 2*i, 32'h0, 1'b0});
            wq.push_back('{17'(32'h100 + rr_ord[i]),
                           8'(32'hA0 + rr_ord[i])});
            fp_q.push_back('{fp_ord[i], n + 3 + 2*i, 32'h0, 1'b0});
        end
        req_rr = 3'b111;
        req_fp = 3'b111;
        nrr = 0;
        nfp = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            req_rr = '0;
            req_fp = '0;
            if (done_rr != 3'b000) begin
                if (nrr < 3) req_rr = done_rr;
                nrr++;
            end
            if (done_fp != 3'b000) begin
                if (nfp < 3) req_fp = done_fp;
                nfp++;
            end
        end
        drain("contention_drain");

        // Single-channel read, four bytes.
        @(negedge clk);
        set_ch(0, 1'b0, 4, 17'h00010, 32'h0);
        exp_q.push_back('{0, cyc + 7, 32'h44332211, 1'b1});
        req_rr = 3'b001;
        @(negedge clk);
        req_rr = '0;
        drain("read_drain");

        // Two-byte write wrapping past the top of the address space.
        @(negedge clk);
        set_ch(1, 1'b1, 2, 17'h1FFFF, 32'h0000ABCD);
        wq.push_back('{17'h1FFFF, 8'hCD});
        wq.push_back('{17'h00000, 8'hAB});
        exp_q.push_back('{1, cyc + 4, 32'h0, 1'b0});
        req_rr = 3'b010;
        @(negedge clk);
        req_rr = '0;
        drain("wrap_drain");

        // Flush on read beat 2 with a write waiting behind it.
        @(negedge clk);
        n = cyc;
        set_ch(0, 1'b0, 4, 17'h00020, 32'h0);
        req_rr = 3'b001;
        @(negedge clk);
        set_ch(2, 1'b1, 1, 17'h00200, 32'h0000005A);
        exp_q.push_back('{2, n + 7, 32'h0, 1'b0});
        wq.push_back('{17'h00200, 8'h5A});
        req_rr = 3'b100;
        @(negedge clk);
        req_rr = '0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_rd_busy", 64'(busy_rr), 64'd0);
        check("flush_rd_rdat_held", 64'(rdat_rr[31:0]), 64'h44332211);
        drain("flush_rd_drain");
        check("flush_rd_rdat_after", 64'(rdat_rr[31:0]), 64'h44332211);

        // Flush on write beat 1 with a same-edge read request.
        @(negedge clk);
        set_ch(1, 1'b1, 4, 17'h00300, 32'h04030201);
        exp_q.push_back('{1, cyc + 6, 32'h0, 1'b0});
        for (int i = 0; i < 4; i++)
            wq.push_back('{17'(32'h300 + i), 8'(i + 1)});
        req_rr = 3'b010;
        @(negedge clk);
        req_rr = '0;
        @(negedge clk);
        @(negedge clk);
        set_ch(0, 1'b0, 1, 17'h00400, 32'h0);
        req_rr = 3'b001;
        flush = 1'b1;
        @(negedge clk);
        req_rr = '0;
        flush = 1'b0;
        drain("flush_wr_drain");
        repeat (8) @(negedge clk);
        check("flush_wr_idle", 64'(busy_rr), 64'd0);

        // Reset while the read is draining its last byte.
        @(negedge clk);
        set_ch(0, 1'b0, 2, 17'h00010, 32'h0);
        req_rr = 3'b001;
        @(negedge clk);
        req_rr = '0;
        repeat (3) @(negedge clk);
        check("drain_busy", 64'(busy_rr), 64'd1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        set_ch(2, 1'b1, 1, 17'h00500, 32'h00000077);
        wq.push_back('{17'h00500, 8'h77});
        exp_q.push_back('{2, cyc + 3, 32'h0, 1'b0});
        req_rr = 3'b100;
        @(negedge clk);
        req_rr = '0;
        drain("post_rst_drain");
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
